// File: rtl/msync_acq_ctrl.sv
// Acquisition/tracking controller for the 31-chip m-sequence despreader (SEARCH -> VERIFY -> LOCK).
// Optional build macro MSYNC_CORR_OUT_EN adds a registered corr_out debug port.
module msync_acq_ctrl #(
    parameter int           N        = 31,
    parameter logic [N-1:0] TEMPLATE = 31'b0110010011111011100010101101000,
    parameter int           THRESH   = 28,
    parameter int           CONFIRM  = 2,
    parameter int           MISS_MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         signal,
    output logic [N-1:0] buff_wr,
    output logic [1:0]   state,
    output logic         locked,
    output logic [4:0]   phase,
    output logic         sync_pulse
`ifdef MSYNC_CORR_OUT_EN
    ,
    output logic [5:0]   corr_out
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    function automatic logic [5:0] match_count(input logic [N-1:0] win);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {5'd0, ~(win[i] ^ TEMPLATE[i])};
        end
        return cnt;
    endfunction

    logic [N-1:0] buff_q, buff_d;
    state_t       state_q, state_d;
    logic         locked_q, locked_d;
    logic [4:0]   phase_q, phase_d, phase_inc;
    logic         sync_q, sync_d;
    logic [CW-1:0] confirm_q, confirm_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [5:0]   corr;
    logic         peak;
    logic         on_time;

    // Correlation is taken from the registered window, so a chip is acted on one edge after it lands.
    assign corr      = match_count(buff_q);
    assign peak      = (corr >= 6'(THRESH));
    assign on_time   = (phase_q == 5'(N - 1));
    assign phase_inc = on_time ? 5'd0 : phase_q + 5'd1;

    always_comb begin
        buff_d    = {buff_q[N-2:0], signal};
        state_d   = state_q;
        phase_d   = phase_inc;
        confirm_d = confirm_q;
        miss_d    = miss_q;
        sync_d    = 1'b0;
        case (state_q)
            SEARCH: begin
                if (peak) begin
                    state_d   = VERIFY;
                    phase_d   = 5'd0;
                    confirm_d = '0;
                end
            end
            VERIFY: begin
                if (on_time) begin
                    if (!peak) begin
                        state_d = SEARCH;
                    end else if (confirm_q >= CW'(CONFIRM - 1)) begin
                        state_d = LOCK;
                        miss_d  = '0;
                    end else begin
                        confirm_d = confirm_q + CW'(1);
                    end
                end
            end
            LOCK: begin
                // Off-time peaks are ignored: no re-phasing once locked.
                if (on_time) begin
                    if (peak) begin
                        sync_d = 1'b1;
                        miss_d = '0;
                    end else begin
                        if (miss_q < MW'(MISS_MAX)) miss_d = miss_q + MW'(1);
                        if (miss_q >= MW'(MISS_MAX - 1)) state_d = SEARCH;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buff_q    <= '0;
            state_q   <= SEARCH;
            locked_q  <= 1'b0;
            phase_q   <= 5'd0;
            sync_q    <= 1'b0;
            confirm_q <= '0;
            miss_q    <= '0;
        end else begin
            buff_q    <= buff_d;
            state_q   <= state_d;
            locked_q  <= locked_d;
            phase_q   <= phase_d;
            sync_q    <= sync_d;
            confirm_q <= confirm_d;
            miss_q    <= miss_d;
        end
    end

`ifdef MSYNC_CORR_OUT_EN
    logic [5:0] corr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_q <= 6'd0;
        end else begin
            corr_q <= corr;
        end
    end

    assign corr_out = corr_q;
`endif

    assign buff_wr    = buff_q;
    assign state      = state_q;
    assign locked     = locked_q;
    assign phase      = phase_q;
    assign sync_pulse = sync_q;

endmodule

// File: tb/tb_msync_acq_ctrl.sv
// Self-checking bench for msync_acq_ctrl: vector tables, scripted lock/miss sequences and
// randomized chip streams compared every cycle against a period/anchor-based reference model.
module tb_msync_acq_ctrl;

    localparam int            N        = 31;
    localparam logic [N-1:0]  TPL      = 31'b0110010011111011100010101101000;
    localparam int            THRESH   = 28;
    localparam int            CONFIRM  = 2;
    localparam int            MISS_MAX = 3;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         signal = 1'b0;
    logic [N-1:0] buff_wr;
    logic [1:0]   state;
    logic         locked;
    logic [4:0]   phase;
    logic         sync_pulse;
`ifdef MSYNC_CORR_OUT_EN
    logic [5:0]   corr_out;
`endif

    msync_acq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .signal     (signal),
        .buff_wr    (buff_wr),
        .state      (state),
        .locked     (locked),
        .phase      (phase),
        .sync_pulse (sync_pulse)
`ifdef MSYNC_CORR_OUT_EN
        ,
        .corr_out   (corr_out)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: chip history, mode, and phase expressed as distance from the last anchor edge.
    bit hist[N];
    int m_mode, m_conf, m_miss, m_t, m_anchor, m_corr_q;
    bit m_sync;

    function automatic int model_corr();
        int c = 0;
        for (int i = 0; i < N; i++) if (hist[i] == TPL[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) hist[i] = 1'b0;
        m_mode = 0; m_conf = 0; m_miss = 0; m_t = 0; m_anchor = 0; m_corr_q = 0; m_sync = 1'b0;
    endtask

    task automatic model_edge(input bit s);
        int  c;
        bit  pk, ont;
        c   = model_corr();
        pk  = (c >= THRESH);
        ont = (((m_t - m_anchor) % N) == N - 1);
        m_sync = 1'b0;
        if (m_mode == 0) begin
            if (pk) begin m_mode = 1; m_anchor = m_t + 1; m_conf = 0; end
        end else if (m_mode == 1) begin
            if (ont) begin
                if (!pk) m_mode = 0;
                else if (m_conf + 1 >= CONFIRM) begin m_mode = 2; m_miss = 0; end
                else m_conf++;
            end
        end else begin
            if (ont) begin
                if (pk) begin m_sync = 1'b1; m_miss = 0; end
                else begin
                    m_miss++;
                    if (m_miss >= MISS_MAX) m_mode = 0;
                end
            end
        end
        m_corr_q = c;
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        m_t++;
    endtask

    task automatic compare_model();
        logic [N-1:0] eb;
        for (int i = 0; i < N; i++) eb[i] = hist[i];
        chk("buff_wr",    64'(buff_wr),    64'(eb));
        chk("state",      64'(state),      64'(m_mode));
        chk("locked",     64'(locked),     64'(m_mode == 2));
        chk("phase",      64'(phase),      64'((m_t - m_anchor) % N));
        chk("sync_pulse", 64'(sync_pulse), 64'(m_sync));
`ifdef MSYNC_CORR_OUT_EN
        chk("corr_out",   64'(corr_out),   64'(m_corr_q));
`endif
    endtask

    task automatic step(input bit s);
        signal = s;
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
        compare_model();
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        signal = 1'($urandom_range(0, 1));
        #1;
        chk("rst_buff_wr",    64'(buff_wr),    64'd0);
        chk("rst_state",      64'(state),      64'd0);
        chk("rst_locked",     64'(locked),     64'd0);
        chk("rst_phase",      64'(phase),      64'd0);
        chk("rst_sync_pulse", 64'(sync_pulse), 64'd0);
`ifdef MSYNC_CORR_OUT_EN
        chk("rst_corr_out",   64'(corr_out),   64'd0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_state", 64'(state), 64'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           rn;
        bit           s;
        logic [N-1:0] eb;
        int           ph;
        int           st;
    } rv_t;

    typedef struct {
        int seq;
        int k;
        int st;
        int lk;
        int sp;
        int ph;
    } ck_t;

    rv_t rtab[7];
    ck_t ctab[21];

    function automatic int pflip(input int p);
        case (p)
            7, 8:       return 4;
            10, 11, 12: return 9;
            13:         return 3;
            15:         return 4;
            default:    return 0;
        endcase
    endfunction

    // Feeds the template cyclically from a fresh reset; chip k (1-based) is template position (k-1)%N.
    task automatic run_seq(input int seq, input int kmax, input bit flips_en);
        for (int k = 1; k <= kmax; k++) begin
            int j, p, nf;
            bit c;
            j  = (k - 1) % N;
            p  = (k - 1) / N + 1;
            nf = flips_en ? pflip(p) : 0;
            c  = TPL[N-1-j];
            if (((5 * j) % N) < nf) c = ~c;
            step(c);
            if (k == N) chk("window_equals_template", 64'(buff_wr), 64'(TPL));
            foreach (ctab[i]) begin
                if (ctab[i].seq == seq && ctab[i].k == k) begin
                    chk($sformatf("seq%0d_k%0d_state", seq, k), 64'(state), 64'(ctab[i].st));
                    chk($sformatf("seq%0d_k%0d_locked", seq, k), 64'(locked), 64'(ctab[i].lk));
                    chk($sformatf("seq%0d_k%0d_sync", seq, k), 64'(sync_pulse), 64'(ctab[i].sp));
                    if (ctab[i].ph >= 0)
                        chk($sformatf("seq%0d_k%0d_phase", seq, k), 64'(phase), 64'(ctab[i].ph));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rtab[0] = '{1'b0, 1'b1, 31'd0,  0, 0};
        rtab[1] = '{1'b0, 1'b0, 31'd0,  0, 0};
        rtab[2] = '{1'b0, 1'b1, 31'd0,  0, 0};
        rtab[3] = '{1'b1, 1'b1, 31'd1,  1, 0};
        rtab[4] = '{1'b1, 1'b0, 31'd2,  2, 0};
        rtab[5] = '{1'b1, 1'b1, 31'd5,  3, 0};
        rtab[6] = '{1'b1, 1'b1, 31'd11, 4, 0};

        ctab[0]  = '{1,  31, 0, 0, 0,  0};
        ctab[1]  = '{1,  32, 1, 0, 0,  0};
        ctab[2]  = '{1,  63, 1, 0, 0,  0};
        ctab[3]  = '{1,  93, 1, 0, 0, 30};
        ctab[4]  = '{1,  94, 2, 1, 0,  0};
        ctab[5]  = '{1, 124, 2, 1, 0, 30};
        ctab[6]  = '{1, 125, 2, 1, 1,  0};
        ctab[7]  = '{1, 126, 2, 1, 0,  1};
        ctab[8]  = '{1, 156, 2, 1, 1,  0};
        ctab[9]  = '{1, 187, 2, 1, 1,  0};
        ctab[10] = '{1, 218, 2, 1, 0,  0};
        ctab[11] = '{1, 249, 2, 1, 0,  0};
        ctab[12] = '{1, 280, 2, 1, 1,  0};
        ctab[13] = '{1, 342, 2, 1, 0,  0};
        ctab[14] = '{1, 373, 0, 0, 0,  0};
        ctab[15] = '{1, 404, 1, 0, 0,  0};
        ctab[16] = '{1, 435, 1, 0, 0,  0};
        ctab[17] = '{1, 466, 0, 0, 0,  0};
        ctab[18] = '{1, 497, 1, 0, 0,  0};
        ctab[19] = '{2,  94, 2, 1, 0,  0};
        ctab[20] = '{2, 125, 2, 1, 1,  0};

        model_reset();
        foreach (rtab[i]) begin
            rst_n  = rtab[i].rn;
            signal = rtab[i].s;
            @(posedge clk);
            if (rtab[i].rn) model_edge(rtab[i].s);
            else            model_reset();
            @(negedge clk);
            chk($sformatf("vec%0d_buff_wr", i), 64'(buff_wr), 64'(rtab[i].eb));
            chk($sformatf("vec%0d_phase", i),   64'(phase),   64'(rtab[i].ph));
            chk($sformatf("vec%0d_state", i),   64'(state),   64'(rtab[i].st));
            chk($sformatf("vec%0d_locked", i),  64'(locked),  64'd0);
            chk($sformatf("vec%0d_sync", i),    64'(sync_pulse), 64'd0);
        end

        // Acquire, lock, tolerate two misses, drop on three, threshold 28 accepted / 27 rejected.
        do_reset();
        run_seq(1, 497, 1'b1);

        // All-zero stream never produces a peak.
        for (int i = 0; i < 200; i++) step(1'b0);
        chk("zeros_state_search", 64'(state), 64'd0);

        // Reset mid-LOCK, then re-acquire from SEARCH.
        do_reset();
        run_seq(2, 110, 1'b0);
        chk("prereset_locked", 64'(locked), 64'd1);
        do_reset();
        run_seq(2, 130, 1'b0);

        // Randomized periods: clean, lightly corrupted, noise, and phase slips.
        for (int p = 0; p < 60; p++) begin
            int r, nf, sl;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                for (int j = 0; j < N; j++) step(TPL[N-1-j]);
            end else if (r <= 7) begin
                nf = $urandom_range(1, 5);
                for (int j = 0; j < N; j++)
                    step(TPL[N-1-j] ^ 1'($urandom_range(0, N - 1) < nf));
            end else if (r == 8) begin
                for (int j = 0; j < N; j++) step(1'($urandom_range(0, 1)));
            end else begin
                sl = $urandom_range(1, N - 1);
                for (int j = 0; j < sl; j++) step(1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
